rx_packet_framer: RTL and testbench

RX_PACKET_FRAMER -- requirements
Module: rx_packet_framer

---
 rtl/rx_packet_framer.sv | 235 +++++++++++++++++++++++
 tb/tb_rx_packet_framer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_packet_framer.sv
// Receive-side packet framer: turns decoded SOP/byte/EOP events into a byte
// stream tagged START/STREAM/STOP/TIMEOUT, with PID, CRC5/CRC16 and error checks.
module rx_packet_framer #(
  parameter logic [15:0] RX_TIMEOUT_CYCLES = 16'd480,
  parameter logic [10:0] MAX_PKT_BYTES     = 11'd1027
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxWaitForPkt,
  input  logic       rxPktStart,
  input  logic [7:0] rxByte,
  input  logic       rxByteValid,
  input  logic       rxBitStuffErr,
  input  logic       rxPktEnd,
  output logic [7:0] RXDataOut,
  output logic       RXDataValid,
  output logic [7:0] RXStreamStatus,
  output logic       SIERxTimeOut
);

  localparam logic [7:0] RX_PACKET_START  = 8'h01;
  localparam logic [7:0] RX_PACKET_STREAM = 8'h02;
  localparam logic [7:0] RX_PACKET_STOP   = 8'h03;
  localparam logic [7:0] RX_TIME_OUT      = 8'h04;

  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
  localparam logic [4:0]  CRC5_INIT      = 5'h1F;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_SOP    = 3'd1,
    GET_PID     = 3'd2,
    GET_BYTES   = 3'd3,
    SEND_STATUS = 3'd4
  } state_t;

  // Bits enter LSB first; the register shifts toward its MSB.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] d);
    logic [4:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[4] ^ d[i]) c = {c[3:0], 1'b0} ^ 5'h05;
      else             c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_to_cnt;
  logic [10:0] r_byte_cnt;
  logic [15:0] r_crc16;
  logic [4:0]  r_crc5;
  logic [3:0]  r_pid;
  logic        r_pid_err;
  logic        r_stuff_err;
  logic        r_ovf;

  logic [7:0]  r_data;
  logic        r_valid;
  logic [7:0]  r_status;
  logic        r_to;

  logic        w_in_pkt;
  logic        w_sop;
  logic        w_timeout;
  logic        w_accept;
  logic        w_is_data;
  logic        w_is_token;
  logic        w_crc_err;
  logic [7:0]  w_stop_byte;
  logic [7:0]  w_out_data;
  logic        w_out_valid;
  logic [7:0]  w_out_status;
  logic        w_out_to;

  assign w_in_pkt  = (r_state == GET_PID) || (r_state == GET_BYTES);
  assign w_sop     = rxPktStart && ((r_state == IDLE) || (r_state == WAIT_SOP));
  // SOP in the final window cycle suppresses the timeout.
  assign w_timeout = (r_state == WAIT_SOP) && !rxPktStart &&
                     (r_to_cnt == (RX_TIMEOUT_CYCLES - 16'd1));
  assign w_accept  = w_in_pkt && rxByteValid && (r_byte_cnt != MAX_PKT_BYTES);

  assign w_is_data  = (r_pid[1:0] == 2'b11);
  assign w_is_token = (r_pid[1:0] == 2'b01);
  // r_byte_cnt includes the PID, so a data packet needs at least 3 bytes.
  assign w_crc_err  = r_pid_err ||
                      (w_is_data  && ((r_crc16 != CRC16_RESIDUAL) || (r_byte_cnt < 11'd3))) ||
                      (w_is_token && (r_crc5 != CRC5_RESIDUAL));
  assign w_stop_byte = {(r_pid == 4'hB), 1'b0, (r_pid == 4'h2), (r_pid == 4'hE),
                        (r_pid == 4'hA), r_ovf, r_stuff_err, w_crc_err};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (rxPktStart)        w_next_state = GET_PID;
        else if (rxWaitForPkt) w_next_state = WAIT_SOP;
      end
      WAIT_SOP: begin
        if (rxPktStart)     w_next_state = GET_PID;
        else if (w_timeout) w_next_state = IDLE;
      end
      GET_PID: begin
        if (rxPktEnd)         w_next_state = SEND_STATUS;
        else if (rxByteValid) w_next_state = GET_BYTES;
      end
      GET_BYTES: begin
        if (rxPktEnd) w_next_state = SEND_STATUS;
      end
      SEND_STATUS: w_next_state = IDLE;
      default:     w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_out_valid  = 1'b0;
    w_out_data   = 8'h00;
    w_out_status = 8'h00;
    w_out_to     = 1'b0;
    case (r_state)
      WAIT_SOP: begin
        if (w_timeout) begin
          w_out_valid  = 1'b1;
          w_out_status = RX_TIME_OUT;
          w_out_to     = 1'b1;
        end
      end
      GET_PID: begin
        if (w_accept) begin
          w_out_valid  = 1'b1;
          w_out_data   = rxByte;
          w_out_status = RX_PACKET_START;
        end
      end
      GET_BYTES: begin
        if (w_accept) begin
          w_out_valid  = 1'b1;
          w_out_data   = rxByte;
          w_out_status = RX_PACKET_STREAM;
        end
      end
      SEND_STATUS: begin
        w_out_valid  = 1'b1;
        w_out_data   = w_stop_byte;
        w_out_status = RX_PACKET_STOP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data   <= 8'h00;
      r_valid  <= 1'b0;
      r_status <= 8'h00;
      r_to     <= 1'b0;
    end else begin
      r_data   <= w_out_data;
      r_valid  <= w_out_valid;
      r_status <= w_out_status;
      r_to     <= w_out_to;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= 16'd0;
    end else if ((r_state == IDLE) && rxWaitForPkt && !rxPktStart) begin
      r_to_cnt <= 16'd0;
    end else if (r_state == WAIT_SOP) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  // Per-packet bookkeeping; SOP restarts everything, a stuff error on the SOP cycle counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt  <= 11'd0;
      r_crc16     <= CRC16_INIT;
      r_crc5      <= CRC5_INIT;
      r_pid       <= 4'h0;
      r_pid_err   <= 1'b0;
      r_stuff_err <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_sop) begin
      r_byte_cnt  <= 11'd0;
      r_crc16     <= CRC16_INIT;
      r_crc5      <= CRC5_INIT;
      r_pid       <= 4'h0;
      r_pid_err   <= 1'b0;
      r_stuff_err <= rxBitStuffErr;
      r_ovf       <= 1'b0;
    end else if (w_in_pkt) begin
      if (rxBitStuffErr) r_stuff_err <= 1'b1;
      if (rxByteValid) begin
        if (r_byte_cnt == MAX_PKT_BYTES) begin
          r_ovf <= 1'b1;
        end else begin
          if (r_byte_cnt != 11'h7FF) r_byte_cnt <= r_byte_cnt + 11'd1;
          if (r_state == GET_PID) begin
            r_pid     <= rxByte[3:0];
            r_pid_err <= (rxByte[7:4] != ~rxByte[3:0]);
          end else begin
            r_crc16 <= crc16_byte(r_crc16, rxByte);
            if (r_byte_cnt < 11'd3) r_crc5 <= crc5_byte(r_crc5, rxByte);
          end
        end
      end
    end
  end

  assign RXDataOut      = r_data;
  assign RXDataValid    = r_valid;
  assign RXStreamStatus = r_status;
  assign SIERxTimeOut   = r_to;

endmodule

// File: tb/tb_rx_packet_framer.sv
// Scoreboard bench for rx_packet_framer: directed packets push expected outputs,
// an independent monitor pops and compares on every RXDataValid.
module tb_rx_packet_framer;

  localparam int MAXB = 1027;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxWaitForPkt, rxPktStart, rxByteValid, rxBitStuffErr, rxPktEnd;
  logic [7:0] rxByte;
  logic [7:0] RXDataOut, RXStreamStatus;
  logic       RXDataValid, SIERxTimeOut;

  rx_packet_framer dut (
    .clk(clk), .rst(rst),
    .rxWaitForPkt(rxWaitForPkt), .rxPktStart(rxPktStart),
    .rxByte(rxByte), .rxByteValid(rxByteValid),
    .rxBitStuffErr(rxBitStuffErr), .rxPktEnd(rxPktEnd),
    .RXDataOut(RXDataOut), .RXDataValid(RXDataValid),
    .RXStreamStatus(RXStreamStatus), .SIERxTimeOut(SIERxTimeOut)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] m;
    logic [7:0] s;
    logic       to;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] pkt [0:1039];
  int         plen;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [7:0] m, input logic [7:0] s, input logic to);
    exp_t e;
    e.d = d; e.m = m; e.s = s; e.to = to;
    q.push_back(e);
  endtask

  task automatic step(input logic s, input logic v, input logic [7:0] b,
                      input logic e, input logic w, input logic se);
    @(negedge clk);
    rxPktStart = s; rxByteValid = v; rxByte = b;
    rxPktEnd = e; rxWaitForPkt = w; rxBitStuffErr = se;
  endtask

  task automatic step0();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Appends the transmitted CRC16 (inverted remainder, MSB sent first) after the PID.
  function automatic void add_crc16();
    logic [15:0] c;
    logic [15:0] inv;
    c = 16'hFFFF;
    for (int i = 1; i < plen; i++)
      for (int k = 0; k < 8; k++)
        c = (c[15] ^ pkt[i][k]) ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
    inv = ~c;
    for (int k = 0; k < 8; k++) begin
      pkt[plen][k]   = inv[15-k];
      pkt[plen+1][k] = inv[7-k];
    end
    plen += 2;
  endfunction

  task automatic send_pkt(input logic [7:0] stop, input logic [7:0] smask);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < plen; i++) begin
      if (i < MAXB) push(pkt[i], 8'hFF, (i == 0) ? 8'h01 : 8'h02, 1'b0);
      step(1'b0, 1'b1, pkt[i], (i == plen - 1), 1'b0, 1'b0);
    end
    push(stop, smask, 8'h03, 1'b0);
    repeat (4) step0();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (RXDataValid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got data=%h status=%h to=%b, expected no output",
                   RXDataOut, RXStreamStatus, SIERxTimeOut);
        end else begin
          e = q.pop_front();
          if (((RXDataOut & e.m) !== (e.d & e.m)) || (RXStreamStatus !== e.s) ||
              (SIERxTimeOut !== e.to)) begin
            errors++;
            $display("FAIL sb_out: got data=%h status=%h to=%b, expected data=%h (mask %h) status=%h to=%b",
                     RXDataOut, RXStreamStatus, SIERxTimeOut, e.d, e.m, e.s, e.to);
          end
        end
      end else if (SIERxTimeOut) begin
        checks++;
        errors++;
        $display("FAIL sb_lone_timeout: got SIERxTimeOut=1 expected 0 without RXDataValid");
      end
    end
  end

  initial begin
    int n;
    bit seen;
    rst = 1'b1;
    rxWaitForPkt = 0; rxPktStart = 0; rxByteValid = 0; rxBitStuffErr = 0; rxPktEnd = 0;
    rxByte = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_data",   {8'h00, RXDataOut},      16'h0000);
    chk("rst_valid",  {15'h0, RXDataValid},    16'h0000);
    chk("rst_status", {8'h00, RXStreamStatus}, 16'h0000);
    chk("rst_to",     {15'h0, SIERxTimeOut},   16'h0000);
    rst = 1'b0;
    repeat (2) step0();

    // Bytes while idle are ignored.
    step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    step0();

    // ACK
    pkt[0] = 8'hD2; plen = 1;
    send_pkt(8'h20, 8'hFF);

    // DATA1 with good CRC16
    pkt[0] = 8'h4B; pkt[1] = 8'h00; pkt[2] = 8'h01; plen = 3; add_crc16();
    send_pkt(8'h80, 8'hFF);

    // Same packet, one payload bit flipped
    pkt[0] = 8'h4B; pkt[1] = 8'h00; pkt[2] = 8'h01; plen = 3; add_crc16();
    pkt[2] = 8'h03;
    send_pkt(8'h81, 8'hFF);

    // Token with good CRC5 (SETUP addr 0 endp 0)
    pkt[0] = 8'h2D; pkt[1] = 8'h00; pkt[2] = 8'h10; plen = 3;
    send_pkt(8'h00, 8'hFF);

    // Short data packet
    pkt[0] = 8'hC3; pkt[1] = 8'h00; plen = 2;
    send_pkt(8'h01, 8'hFF);

    // PID check nibble wrong; PID nibble still reads as ACK
    pkt[0] = 8'h22; plen = 1;
    send_pkt(8'h21, 8'hFF);

    pkt[0] = 8'h5A; plen = 1;
    send_pkt(8'h08, 8'hFF);
    pkt[0] = 8'h1E; plen = 1;
    send_pkt(8'h10, 8'hFF);

    // Timeout: pulse must appear exactly 480 cycles after the arm edge
    push(8'h00, 8'hFF, 8'h04, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step0();
    n = 0; seen = 0;
    while (!seen && n < 600) begin
      @(posedge clk);
      n++;
      #1;
      if (SIERxTimeOut) seen = 1;
    end
    chk("timeout_cycle", seen ? 16'(n) : 16'hFFFF, 16'd480);
    repeat (4) step0();

    // SOP on the final window cycle wins over timeout
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    repeat (479) step0();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    push(8'hD2, 8'hFF, 8'h01, 1'b0);
    step(1'b0, 1'b1, 8'hD2, 1'b1, 1'b0, 1'b0);
    push(8'h20, 8'hFF, 8'h03, 1'b0);
    repeat (4) step0();

    // Overflow: a valid 1027-byte DATA0 followed by 3 extra bytes
    pkt[0] = 8'hC3;
    for (int i = 1; i <= 1024; i++) pkt[i] = 8'(i);
    plen = 1025; add_crc16();
    pkt[1027] = 8'h11; pkt[1028] = 8'h22; pkt[1029] = 8'h33; plen = 1030;
    send_pkt(8'h04, 8'hFE);

    // Bit-stuff error mid ACK, then a clean ACK
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    push(8'hD2, 8'hFF, 8'h01, 1'b0);
    step(1'b0, 1'b1, 8'hD2, 1'b1, 1'b0, 1'b0);
    push(8'h22, 8'hFF, 8'h03, 1'b0);
    repeat (4) step0();
    pkt[0] = 8'hD2; plen = 1;
    send_pkt(8'h20, 8'hFF);

    // Reset mid-packet: no STOP, trailing bytes ignored
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    push(8'h4B, 8'hFF, 8'h01, 1'b0);
    step(1'b0, 1'b1, 8'h4B, 1'b0, 1'b0, 1'b0);
    push(8'h00, 8'hFF, 8'h02, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    step0();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", {15'h0, RXDataValid},    16'h0000);
    chk("midrst_data",  {8'h00, RXDataOut},      16'h0000);
    step(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
    repeat (10) step0();

    chk("sb_drained", 16'(q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
